parity_frame_tx: RTL and testbench
==================================

# parity_frame_tx

Serial framing controller for the odd/even parity generator. It accepts WIDTH-bit words over a valid/ready handshake and computes the parity bit in the selected mode (even or odd). It then sequences a fixed frame onto a single serial line: start bit, data bits LSB first, parity bit, stop bit, each held for DIV clocks. It sits between a word producer and the serial link, and is the only user of the parity datapath.

## Interface
Parameters:
- WIDTH, 3, data bits per frame (≥1)
- DIV, 4, clocks per serial bit (≥1)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  producer has a word on in_data
- in_data  input  WIDTH  word to transmit
- odd_sel  input  1  1 = odd parity, 0 = even parity; sampled only at accept
- in_ready  output  1  block can accept a word; high only in IDLE
- tx  output  1  serial line; idles high
- busy  output  1  high in every non-IDLE state
- done  output  1  one-cycle pulse on the last clock of the stop bit
- parity_out  output  1  parity bit of the most recently accepted word

## Operation
- States and order: IDLE → START → DATA → PARITY → STOP → IDLE.
- Accept:
  - occurs at a rising edge where state = IDLE and in_valid = 1;
  - latches in_data into the shift register and odd_sel into the mode register;
  - computes parity = ^in_data (even mode) or ~^in_data (odd mode) and registers it into parity_out;
  - moves to START.
- tx levels per state:
  - START: tx = 0.
  - DATA: tx = shift register bit 0; the register shifts right every DIV clocks; the bit counter runs 0..WIDTH-1.
  - PARITY: tx = parity_out.
  - STOP: tx = 1.
  - IDLE: tx = 1.
- Bit timer runs 0..DIV-1. A state or bit advances when the timer = DIV-1, and the timer then wraps to 0.
- Within DATA, the state exits to PARITY when the timer = DIV-1 and the bit counter = WIDTH-1.
- Both counters are sized with $clog2. When DIV = 1 the timer is constant 0 and every bit lasts one clock.
- in_valid outside IDLE is ignored. It does not queue, and in_data/odd_sel changes mid-frame have no effect.
- Reset (rst_n low, any time, including mid-frame):
  - immediately forces state to IDLE, tx = 1, busy = 0, done = 0, in_ready = 1, parity_out = 0;
  - clears both counters and the shift register;
  - discards the partial frame.
- No word is accepted on an edge while rst_n is low.

## Timing
- Accept at edge k: tx falls at edge k+1 (first START cycle).
- Frame length is (WIDTH+3)·DIV clocks: edges k+1 through k+(WIDTH+3)·DIV.
- START occupies cycles 1..DIV after accept. Data bit i occupies cycles (i+1)·DIV+1 .. (i+2)·DIV.
- done = 1 for the single cycle in which state = STOP and timer = DIV-1. The next edge returns to IDLE.
- in_ready and busy are decoded directly from the state register with zero delay. in_ready rises in the first IDLE cycle after STOP.
- Back-to-back: a word offered with in_valid held high is accepted on the first IDLE edge. Exactly one IDLE cycle (tx = 1) separates consecutive frames.
- parity_out updates on the accept edge and holds until the next accept or reset.

## Test plan
- Reset values: rst_n low → tx = 1, in_ready = 1, busy = 0, done = 0, parity_out = 0.
- Even mode (WIDTH = 3, DIV = 4): in_data = 3'b101, odd_sel = 0.
  - parity_out = 0.
  - tx over 24 clocks = 0,1,0,1,0,1, each held 4 cycles.
  - done pulses at cycle 24 after accept.
- Odd mode: in_data = 3'b000, odd_sel = 1.
  - parity_out = 1.
  - tx = 0,0,0,0,1,1 per 4-cycle bit.
- Exhaustive: all 8 words × both modes.
  - parity_out matches XOR/XNOR.
  - Total count of ones in data plus parity is even (even mode) or odd (odd mode).
- Busy guard: assert in_valid with 3'b111 at cycle 5 of a frame carrying 3'b010.
  - It is not accepted, in_ready = 0, and the frame remains 3'b010.
  - With in_valid held high, 3'b111 is accepted on the first IDLE edge, leaving one tx = 1 gap.
- Mid-frame reset: pull rst_n low during DATA bit 1.
  - tx = 1 and busy = 0 immediately, with no done pulse.
  - After release, a new word transmits a full, correct frame.

Source files
------------

// File: rtl/parity_frame_tx_if.sv
// Word handshake and serial-line bundle for parity_frame_tx.
// The master is the word producer. The slave is the framing controller.
interface parity_frame_tx_if #(
  parameter int WIDTH = 3
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             odd_sel;
  logic             in_ready;
  logic             tx;
  logic             busy;
  logic             done;
  logic             parity_out;

  modport master (
    output in_valid, in_data, odd_sel,
    input  in_ready, tx, busy, done, parity_out
  );

  modport slave (
    input  in_valid, in_data, odd_sel,
    output in_ready, tx, busy, done, parity_out
  );
endinterface

// File: rtl/parity_frame_tx.sv
// Serial framing controller with an even/odd parity generator.
// Each accepted word is sent as one frame: a start bit, then the data bits
// LSB first, then the parity bit, then a stop bit. Every bit lasts DIV clocks.
module parity_frame_tx #(
  parameter int WIDTH = 3,
  parameter int DIV   = 4
) (
  input logic              clk,
  input logic              rst_n,
  parity_frame_tx_if.slave bus
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  localparam logic [BW-1:0] BMAX = BW'(WIDTH - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             mode_q, mode_d;      // 1 = odd parity
  logic             dpar_q, dpar_d;      // XOR of the accepted word
  logic             tick;

  assign tick = (timer_q == TMAX);

  // Next-state logic: accept in IDLE, then step through the frame on each bit-timer wrap.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    state_d = state_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    mode_d  = mode_q;
    dpar_d  = dpar_q;

    if (state_q != S_IDLE) begin
      timer_d = tick ? '0 : timer_q + TW'(1);
    end

    case (state_q)
      S_IDLE: begin
        timer_d = '0;
        bit_d   = '0;
        if (bus.in_valid) begin
          shift_d = bus.in_data;
          mode_d  = bus.odd_sel;
          dpar_d  = ^bus.in_data;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) state_d = S_DATA;
      end
      S_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_q == BMAX) begin
            state_d = S_PARITY;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) state_d = S_STOP;
      end
      S_STOP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers. Reset clears everything and discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register is ordinary flops, not a memory, so it is reset along with the rest.
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      mode_q  <= 1'b0;
      dpar_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments, so every flop samples pre-edge values.
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      mode_q  <= mode_d;
      dpar_q  <= dpar_d;
    end
  end

  // Output decode. All terms come straight from registers, with no extra latency.
  always_comb begin
    bus.in_ready   = (state_q == S_IDLE);
    bus.busy       = (state_q != S_IDLE);
    bus.done       = (state_q == S_STOP) && tick;
    bus.parity_out = dpar_q ^ mode_q;
    case (state_q)
      S_START:  bus.tx = 1'b0;
      S_DATA:   bus.tx = shift_q[0];
      S_PARITY: bus.tx = dpar_q ^ mode_q;
      default:  bus.tx = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed bench for parity_frame_tx with WIDTH=3 and DIV=4.
// Inputs are driven on negedges, and outputs are sampled on negedges.
module tb_parity_frame_tx;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests_run = 0;
  int   tests_failed = 0;

  parity_frame_tx_if #(.WIDTH(3)) bus ();

  parity_frame_tx #(.WIDTH(3), .DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Expand six serial bits (bit 0 goes out first) into a 24-cycle waveform, 4 cycles per bit.
  function automatic logic [23:0] expand(input logic [5:0] bits);
    logic [23:0] w;
    for (int c = 0; c < 24; c++) w[c] = bits[c / 4];
    return w;
  endfunction

  // Offer a word at a negedge with the DUT idle, then capture 24 frame cycles.
  // If inject > 0, 3'b111 (even mode) is offered from frame cycle 'inject' onward and left asserted.
  task automatic send(input logic [2:0] d, input logic odd, input int inject,
                      output logic [23:0] tx_w, output logic [23:0] done_w,
                      output logic [23:0] busy_w, output logic par);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.odd_sel  = odd;
    @(posedge clk);
    for (int c = 0; c < 24; c++) begin
      @(negedge clk);
      if (c == 0) begin
        bus.in_valid = 1'b0;
        bus.in_data  = ~d;
        bus.odd_sel  = ~odd;
        par = bus.parity_out;
      end
      if (inject > 0 && c == inject - 1) begin
        bus.in_valid = 1'b1;
        bus.in_data  = 3'b111;
        bus.odd_sel  = 1'b0;
        #1;
        check("guard_in_ready", 32'(bus.in_ready), 32'd0);
      end
      tx_w[c]   = bus.tx;
      done_w[c] = bus.done;
      busy_w[c] = bus.busy;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] tx_w, done_w, busy_w;
    logic        par;
    logic        exp_par;

    bus.in_valid = 1'b0;
    bus.in_data  = 3'b000;
    bus.odd_sel  = 1'b0;

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_tx", 32'(bus.tx), 32'd1);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_parity", 32'(bus.parity_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Even mode, 101: serial bits 0,1,0,1,0,1.
    send(3'b101, 1'b0, 0, tx_w, done_w, busy_w, par);
    check("even_parity", 32'(par), 32'd0);
    check("even_tx", 32'(tx_w), 32'(expand(6'b101010)));
    check("even_done", 32'(done_w), 32'h80_0000);
    check("even_busy", 32'(busy_w), 32'hFF_FFFF);
    @(negedge clk);
    check("even_idle_ready", 32'(bus.in_ready), 32'd1);
    check("even_idle_tx", 32'(bus.tx), 32'd1);
    check("even_parity_hold", 32'(bus.parity_out), 32'd0);

    // Odd mode, 000: serial bits 0,0,0,0,1,1.
    send(3'b000, 1'b1, 0, tx_w, done_w, busy_w, par);
    check("odd_parity", 32'(par), 32'd1);
    check("odd_tx", 32'(tx_w), 32'(expand(6'b110000)));
    check("odd_done", 32'(done_w), 32'h80_0000);
    @(negedge clk);

    // All words in both modes.
    for (int m = 0; m < 2; m++) begin
      for (int v = 0; v < 8; v++) begin
        logic [2:0] d;
        d = 3'(v);
        exp_par = (^d) ^ m[0];
        send(d, m[0], 0, tx_w, done_w, busy_w, par);
        check($sformatf("exh_par_m%0d_d%0d", m, v), 32'(par), 32'(exp_par));
        check($sformatf("exh_ones_m%0d_d%0d", m, v),
              32'(($countones(d) + int'(par)) % 2), 32'(m));
        check($sformatf("exh_tx_m%0d_d%0d", m, v), 32'(tx_w),
              32'(expand({1'b1, exp_par, d, 1'b0})));
        @(negedge clk);
      end
    end

    // Busy guard: 3'b111 is offered during cycle 5 of a 3'b010 frame.
    send(3'b010, 1'b0, 5, tx_w, done_w, busy_w, par);
    check("guard_par", 32'(par), 32'd1);
    check("guard_tx", 32'(tx_w), 32'(expand({1'b1, 1'b1, 3'b010, 1'b0})));
    check("guard_done", 32'(done_w), 32'h80_0000);
    @(negedge clk);
    check("guard_gap_tx", 32'(bus.tx), 32'd1);
    check("guard_gap_ready", 32'(bus.in_ready), 32'd1);
    // in_valid is still high here, so 3'b111 goes out at the next edge.
    send(3'b111, 1'b0, 0, tx_w, done_w, busy_w, par);
    check("guard2_par", 32'(par), 32'd1);
    check("guard2_tx", 32'(tx_w), 32'(expand({1'b1, 1'b1, 3'b111, 1'b0})));
    @(negedge clk);

    // Mid-frame reset during data bit 1 (frame cycles 9..12).
    bus.in_valid = 1'b1;
    bus.in_data  = 3'b110;
    bus.odd_sel  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_tx", 32'(bus.tx), 32'd1);
    check("mrst_busy", 32'(bus.busy), 32'd0);
    check("mrst_done", 32'(bus.done), 32'd0);
    check("mrst_ready", 32'(bus.in_ready), 32'd1);
    check("mrst_parity", 32'(bus.parity_out), 32'd0);
    done_w = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      done_w[c] = bus.done;
    end
    check("mrst_no_done", 32'(done_w), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(3'b011, 1'b1, 0, tx_w, done_w, busy_w, par);
    check("post_rst_par", 32'(par), 32'd1);
    check("post_rst_tx", 32'(tx_w), 32'(expand({1'b1, 1'b1, 3'b011, 1'b0})));
    check("post_rst_done", 32'(done_w), 32'h80_0000);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
